// File: rtl/end_screen_renderer.sv
// Win/lose end-of-bout screen: blinking box with a WIN or LOSE glyph, held for a
// frame count before flagging done. Two-stage pixel pipeline (hit flags, then colour).
module end_screen_renderer #(
  parameter int          BOX_X        = 380,
  parameter int          BOX_Y        = 220,
  parameter int          BOX_SIZE     = 200,
  parameter int          STROKE       = 20,
  parameter logic [23:0] BOX_COLOR    = 24'hF4_63_05,
  parameter logic [23:0] ALT_COLOR    = 24'h80_30_00,
  parameter logic [23:0] GLYPH_COLOR  = 24'hFF_FF_FF,
  parameter int          BLINK_FRAMES = 30,
  parameter int          HOLD_FRAMES  = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic        result_vld_in,
  input  logic        result_win_in,
  input  logic        ack_in,
  output logic [23:0] color_out,
  output logic        active_out,
  output logic        done_out
);

  localparam int FRAME_W = $clog2(HOLD_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam int WIN_X [4] = '{BOX_X + 40, BOX_X + 90, BOX_X + 140, BOX_X + 40};
  localparam int WIN_Y [4] = '{BOX_Y + 50, BOX_Y + 105, BOX_Y + 50, BOX_Y + 150};
  localparam int WIN_W [4] = '{STROKE, STROKE, STROKE, 120};
  localparam int WIN_H [4] = '{100, 100, 100, STROKE};
  localparam int LOSE_X [2] = '{BOX_X + 60, BOX_X + 60};
  localparam int LOSE_Y [2] = '{BOX_Y + 50, BOX_Y + 150};
  localparam int LOSE_W [2] = '{STROKE, 80};
  localparam int LOSE_H [2] = '{100, STROKE};

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 win_reg, win_next;
  logic                 phase_reg, phase_next;
  logic [FRAME_W-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
  logic                 active_reg, done_reg;

  // Rectangle test on 12-bit unsigned coordinates; the far edge wraps like the hardware adder.
  function automatic logic in_rect(input logic [11:0] hc, input logic [11:0] vc,
                                   input logic [11:0] x, input logic [11:0] y,
                                   input logic [11:0] w, input logic [11:0] h);
    logic [11:0] x_end;
    logic [11:0] y_end;
    x_end = x + w;
    y_end = y + h;
    return (hc >= x) && (hc < x_end) && (vc >= y) && (vc < y_end);
  endfunction

  logic [11:0] hc12, vc12;
  logic [3:0]  win_hits;
  logic [1:0]  lose_hits;
  logic        box_hit;

  assign hc12    = {1'b0, hcount_in};
  assign vc12    = {2'b00, vcount_in};
  assign box_hit = in_rect(hc12, vc12, 12'(BOX_X), 12'(BOX_Y), 12'(BOX_SIZE), 12'(BOX_SIZE));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
      assign win_hits[gi] = in_rect(hc12, vc12, 12'(WIN_X[gi]), 12'(WIN_Y[gi]),
                                    12'(WIN_W[gi]), 12'(WIN_H[gi]));
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_lose
      assign lose_hits[gi] = in_rect(hc12, vc12, 12'(LOSE_X[gi]), 12'(LOSE_Y[gi]),
                                     12'(LOSE_W[gi]), 12'(LOSE_H[gi]));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    win_next       = win_reg;
    phase_next     = phase_reg;
    frame_cnt_next = frame_cnt_reg;
    blink_cnt_next = blink_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (result_vld_in) begin
          state_next     = SHOW;
          win_next       = result_win_in;
          phase_next     = 1'b0;
          frame_cnt_next = '0;
          blink_cnt_next = '0;
        end
      end
      SHOW: begin
        // A skip request outranks any frame tick arriving in the same cycle.
        if (ack_in) begin
          state_next = IDLE;
        end else if (new_frame_in) begin
          frame_cnt_next = frame_cnt_reg + 1'b1;
          if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
          if (frame_cnt_reg == FRAME_W'(HOLD_FRAMES - 1))
            state_next = DONE;
        end
      end
      DONE: begin
        if (ack_in)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      win_reg       <= 1'b0;
      phase_reg     <= 1'b0;
      frame_cnt_reg <= '0;
      blink_cnt_reg <= '0;
      active_reg    <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      win_reg       <= win_next;
      phase_reg     <= phase_next;
      frame_cnt_reg <= frame_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      active_reg    <= (state_reg != IDLE);
      done_reg      <= (state_reg == DONE);
    end
  end

  // Stage 1 captures state and phase alongside the hit flags so each pixel is self-consistent.
  logic        s1_box_reg, s1_stroke_reg, s1_idle_reg, s1_phase_reg;
  logic [23:0] color_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_box_reg    <= 1'b0;
      s1_stroke_reg <= 1'b0;
      s1_idle_reg   <= 1'b1;
      s1_phase_reg  <= 1'b0;
      color_reg     <= '0;
    end else begin
      s1_box_reg    <= box_hit;
      s1_stroke_reg <= win_reg ? (|win_hits) : (|lose_hits);
      s1_idle_reg   <= (state_reg == IDLE);
      s1_phase_reg  <= phase_reg;
      if (s1_idle_reg)
        color_reg <= '0;
      else if (s1_stroke_reg)
        color_reg <= GLYPH_COLOR;
      else if (s1_box_reg)
        color_reg <= s1_phase_reg ? ALT_COLOR : BOX_COLOR;
      else
        color_reg <= '0;
    end
  end

  assign color_out  = color_reg;
  assign active_out = active_reg;
  assign done_out   = done_reg;

endmodule

// File: tb/tb_end_screen_renderer.sv
// Directed + randomized bench for end_screen_renderer with a frame-count model
// of the screen (phase derived from total frames shown, colour from rectangle rules).
module tb_end_screen_renderer;

  localparam int BLINK = 2;
  localparam int HOLD  = 5;
  localparam int BX = 380, BY = 220, BS = 200, ST = 20;
  localparam logic [23:0] C_BOX   = 24'hF4_63_05;
  localparam logic [23:0] C_ALT   = 24'h80_30_00;
  localparam logic [23:0] C_GLYPH = 24'hFF_FF_FF;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        new_frame_in = 1'b0;
  logic        result_vld_in = 1'b0;
  logic        result_win_in = 1'b0;
  logic        ack_in = 1'b0;
  logic [23:0] color_out;
  logic        active_out;
  logic        done_out;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0=idle, 1=showing, 2=done; frames = frame pulses counted since the result.
  int m_state = 0;
  bit m_win = 1'b0;
  int m_frames = 0;

  end_screen_renderer #(
    .BLINK_FRAMES(BLINK),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .new_frame_in (new_frame_in),
    .result_vld_in(result_vld_in),
    .result_win_in(result_win_in),
    .ack_in       (ack_in),
    .color_out    (color_out),
    .active_out   (active_out),
    .done_out     (done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit hit(input int hc, input int vc, input int x, input int y,
                             input int w, input int h);
    return (hc >= x) && (hc < x + w) && (vc >= y) && (vc < y + h);
  endfunction

  function automatic logic [23:0] model_color(input int hc, input int vc);
    bit stroke;
    if (m_state == 0) return 24'h0;
    if (m_win)
      stroke = hit(hc, vc, BX + 40, BY + 50, ST, 100) || hit(hc, vc, BX + 90, BY + 105, ST, 100) ||
               hit(hc, vc, BX + 140, BY + 50, ST, 100) || hit(hc, vc, BX + 40, BY + 150, 120, ST);
    else
      stroke = hit(hc, vc, BX + 60, BY + 50, ST, 100) || hit(hc, vc, BX + 60, BY + 150, 80, ST);
    if (stroke) return C_GLYPH;
    if (hit(hc, vc, BX, BY, BS, BS)) return (((m_frames / BLINK) % 2) == 1) ? C_ALT : C_BOX;
    return 24'h0;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pixel(input string tag, input int hc, input int vc);
    hcount_in = 11'(hc);
    vcount_in = 10'(vc);
    tick();
    tick();
    check($sformatf("%s(%0d,%0d)", tag, hc, vc), {8'h0, color_out}, {8'h0, model_color(hc, vc)});
  endtask

  task automatic check_status(input string tag);
    tick();
    tick();
    check({tag, "_active"}, {31'h0, active_out}, 32'(m_state != 0));
    check({tag, "_done"}, {31'h0, done_out}, 32'(m_state == 2));
  endtask

  task automatic random_pixels(input string tag, input int n);
    for (int i = 0; i < n; i++)
      check_pixel(tag, int'($urandom_range(600, 360)), int'($urandom_range(440, 200)));
  endtask

  task automatic pulse_result(input bit w);
    result_vld_in = 1'b1;
    result_win_in = w;
    tick();
    result_vld_in = 1'b0;
    if (m_state == 0) begin
      m_state = 1; m_win = w; m_frames = 0;
    end
  endtask

  task automatic pulse_frame();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    if (m_state == 1) begin
      m_frames++;
      if (m_frames == HOLD) m_state = 2;
    end
  endtask

  task automatic pulse_ack();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    m_state = 0;
  endtask

  task automatic pulse_result_frame(input bit w);
    result_vld_in = 1'b1;
    result_win_in = w;
    new_frame_in  = 1'b1;
    tick();
    result_vld_in = 1'b0;
    new_frame_in  = 1'b0;
    if (m_state == 0) begin
      m_state = 1; m_win = w; m_frames = 0;
    end
  endtask

  task automatic pulse_ack_frame();
    ack_in = 1'b1;
    new_frame_in = 1'b1;
    tick();
    ack_in = 1'b0;
    new_frame_in = 1'b0;
    m_state = 0;
  endtask

  initial begin
    rst_in = 1'b1;
    tick(); tick(); tick();
    rst_in = 1'b0;
    check_status("reset");
    check_pixel("reset_px", 480, 320);

    pulse_ack();
    check_status("ack_idle");

    // LOSE glyph
    pulse_result(1'b0);
    check_status("lose_show");
    check_pixel("lose", 470, 300);
    check_pixel("lose", 530, 300);
    check_pixel("lose", 379, 300);
    check_pixel("lose", 440, 270);
    check_pixel("lose", 450, 375);
    check_pixel("lose", 519, 389);
    check_pixel("lose", 579, 419);
    check_pixel("lose", 580, 420);
    random_pixels("lose_rnd", 20);

    // Result during SHOW must not overwrite the glyph
    pulse_result(1'b1);
    check_pixel("lose_keep", 470, 325);
    check_pixel("lose_keep", 530, 300);

    // Blink and hold timing
    for (int i = 1; i < HOLD; i++) begin
      pulse_frame();
      check_pixel($sformatf("blink_f%0d", i), 395, 235);
      check_status($sformatf("hold_f%0d", i));
    end
    pulse_frame();
    check_status("done_rise");
    check_pixel("done_frozen", 395, 235);
    pulse_frame();
    pulse_frame();
    check_pixel("done_frozen2", 395, 235);
    check_status("done_stay");
    pulse_ack();
    check_status("done_ack");
    check_pixel("after_ack", 450, 300);

    // Result and frame pulse together: frame not counted
    pulse_result_frame(1'b1);
    pulse_frame();
    check_pixel("win_phase", 395, 235);
    check_pixel("win", 470, 325);
    check_pixel("win", 530, 300);
    check_pixel("win", 500, 380);
    check_pixel("win", 470, 300);
    random_pixels("win_rnd", 20);

    // Skip from SHOW with a simultaneous frame pulse
    pulse_ack_frame();
    check_status("skip");
    check_pixel("skip_px", 500, 380);

    // Reset mid-line while a glyph pixel is in flight
    pulse_result(1'b0);
    pulse_frame();
    pulse_frame();
    pulse_frame();
    check_pixel("pre_rst", 395, 235);
    hcount_in = 11'd450;
    vcount_in = 10'd300;
    tick();
    rst_in = 1'b1;
    tick();
    m_state = 0; m_win = 1'b0; m_frames = 0;
    check("rst_color", {8'h0, color_out}, 32'h0);
    check("rst_active", {31'h0, active_out}, 32'h0);
    check("rst_done", {31'h0, done_out}, 32'h0);
    rst_in = 1'b0;
    check_pixel("post_rst", 450, 300);

    pulse_result(1'b1);
    pulse_frame();
    check_pixel("post_rst_phase", 395, 235);
    for (int i = 0; i < HOLD; i++) pulse_frame();
    check_status("post_rst_done");
    random_pixels("done_rnd", 20);
    pulse_ack();
    check_status("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
